// File: rtl/syn_ram_fifo_ctrl_if.sv
// Producer/consumer side of the RAM-backed FIFO: push/pop requests, read strobe and occupancy flags.
interface syn_ram_fifo_ctrl_if #(
  parameter int RAM_WIDTH = 8,
  parameter int ADDR_SIZE = 4
);
  logic                 wr_en;
  logic [RAM_WIDTH-1:0] wr_data;
  logic                 rd_en;
  logic                 rd_valid;
  logic                 full;
  logic                 almost_full;
  logic                 empty;
  logic [ADDR_SIZE:0]   count;
  logic                 overflow;
  logic                 underflow;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_valid, full, almost_full, empty, count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_valid, full, almost_full, empty, count, overflow, underflow
  );
endinterface

// File: rtl/syn_ram_fifo_ctrl.sv
// Push/pop controller that turns a 16x8 synchronous dual-port RAM into a FIFO.
// Occupancy flags are registered from the pointer values after each edge.
module syn_ram_fifo_ctrl #(
  parameter int RAM_WIDTH    = 8,
  parameter int RAM_DEPTH    = 16,
  parameter int ADDR_SIZE    = 4,
  parameter int AFULL_THRESH = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  syn_ram_fifo_ctrl_if.slave    bus,
  output logic                  ram_write,
  output logic                  ram_read,
  output logic [ADDR_SIZE-1:0]  ram_wr_addr,
  output logic [ADDR_SIZE-1:0]  ram_rd_addr,
  output logic [RAM_WIDTH-1:0]  ram_data_in
);
  localparam logic [ADDR_SIZE:0] DEPTH_C = (ADDR_SIZE+1)'(RAM_DEPTH);
  localparam logic [ADDR_SIZE:0] AFULL_C = (ADDR_SIZE+1)'(AFULL_THRESH);
  localparam logic [ADDR_SIZE:0] ZERO_C  = '0;

  logic [ADDR_SIZE:0] wr_ptr;
  logic [ADDR_SIZE:0] rd_ptr;
  logic [ADDR_SIZE:0] wr_ptr_nxt;
  logic [ADDR_SIZE:0] rd_ptr_nxt;
  logic [ADDR_SIZE:0] count_nxt;
  logic               push_ok;
  logic               pop_ok;

  // Gating on the registered full/empty flags keeps the RAM ports from
  // ever addressing the same location in one cycle.
  assign push_ok = bus.wr_en & ~bus.full  & ~reset;
  assign pop_ok  = bus.rd_en & ~bus.empty & ~reset;

  assign ram_write   = push_ok;
  assign ram_read    = pop_ok;
  assign ram_data_in = bus.wr_data;
  assign ram_wr_addr = wr_ptr[ADDR_SIZE-1:0];
  assign ram_rd_addr = rd_ptr[ADDR_SIZE-1:0];

  assign wr_ptr_nxt = wr_ptr + {{ADDR_SIZE{1'b0}}, push_ok};
  assign rd_ptr_nxt = rd_ptr + {{ADDR_SIZE{1'b0}}, pop_ok};
  assign count_nxt  = wr_ptr_nxt - rd_ptr_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      bus.count       <= '0;
      bus.empty       <= 1'b1;
      bus.full        <= 1'b0;
      bus.almost_full <= 1'b0;
      bus.rd_valid    <= 1'b0;
      bus.overflow    <= 1'b0;
      bus.underflow   <= 1'b0;
    end else begin
      wr_ptr          <= wr_ptr_nxt;
      rd_ptr          <= rd_ptr_nxt;
      bus.count       <= count_nxt;
      bus.empty       <= (count_nxt == ZERO_C);
      bus.full        <= (count_nxt == DEPTH_C);
      bus.almost_full <= (count_nxt >= AFULL_C);
      // RAM data_out lags the read strobe by one cycle.
      bus.rd_valid    <= pop_ok;
      bus.overflow    <= bus.overflow  | (bus.wr_en & bus.full);
      bus.underflow   <= bus.underflow | (bus.rd_en & bus.empty);
    end
  end
endmodule

// File: doc/syn_ram_fifo_ctrl.md
Name: syn_ram_fifo_ctrl

Overview:
Write/read controller that sits directly upstream of the 16x8 synchronous dual-port RAM (syn_ram) and turns it into a synchronous FIFO. It accepts push/pop requests from producer and consumer. It drives the RAM's write, read, wr_addr, rd_addr and data_in ports, and tracks occupancy with full, empty, almost-full and error flags. Read data is taken by the consumer straight from the RAM's data_out; this block supplies the matching valid strobe.

Parameters:
RAM_WIDTH, 8, data word width; must equal the RAM's width
RAM_DEPTH, 16, number of entries; must equal 2**ADDR_SIZE
ADDR_SIZE, 4, RAM address width
AFULL_THRESH, 14, almost_full asserts when count >= AFULL_THRESH (1..RAM_DEPTH)

Ports:
clk  input  1  rising-edge clock, shared with syn_ram
reset  input  1  synchronous, active-high; does not drive the RAM's own reset
wr_en  input  1  push request from producer
wr_data  input  RAM_WIDTH  push data
rd_en  input  1  pop request from consumer
rd_valid  output  1  RAM data_out holds the popped word this cycle
full  output  1  count == RAM_DEPTH
almost_full  output  1  count >= AFULL_THRESH
empty  output  1  count == 0
count  output  ADDR_SIZE+1  current occupancy, 0..RAM_DEPTH
overflow  output  1  sticky: a push was rejected because the FIFO was full
underflow  output  1  sticky: a pop was rejected because the FIFO was empty
ram_write  output  1  to RAM write
ram_read  output  1  to RAM read
ram_wr_addr  output  ADDR_SIZE  to RAM wr_addr
ram_rd_addr  output  ADDR_SIZE  to RAM rd_addr
ram_data_in  output  RAM_WIDTH  to RAM data_in

Behaviour:
- Reset values (on a clock edge with reset=1):
  - wr_ptr, rd_ptr, count = 0
  - empty=1, full=0, almost_full=0
  - rd_valid=0, overflow=0, underflow=0
  - reset overrides wr_en/rd_en in the same cycle.
- Pointers:
  - wr_ptr and rd_ptr are ADDR_SIZE+1 bits; the MSB is a wrap bit.
  - ram_wr_addr = wr_ptr[ADDR_SIZE-1:0]; ram_rd_addr = rd_ptr[ADDR_SIZE-1:0].
  - Addresses wrap from 15 to 0.
- Flags:
  - full, empty, almost_full and count are registered, derived from state after each edge.
  - count = wr_ptr - rd_ptr, modulo 2**(ADDR_SIZE+1).
- Push:
  - push_ok = wr_en & ~full, evaluated on current registered flags.
  - ram_write = push_ok (combinational); ram_data_in = wr_data (combinational).
  - On the edge: RAM stores the word and wr_ptr increments.
- Pop:
  - pop_ok = rd_en & ~empty.
  - ram_read = pop_ok (combinational); rd_ptr increments on the edge.
  - RAM data_out is registered, one-cycle latency: rd_valid = pop_ok delayed by one cycle.
  - Consumer samples RAM data_out while rd_valid=1.
- Simultaneous push and pop:
  - Not full and not empty: both accepted, count unchanged.
  - Full: pop accepted, push rejected (overflow set), count = RAM_DEPTH-1.
  - Empty: push accepted, pop rejected (underflow set), count = 1.
  - No same-cycle bypass in either case.
- Rejected requests: no RAM strobe, pointers unchanged, corresponding sticky flag set. Sticky flags clear only on reset.
- RAM address hazard: write and read never target the same address in one cycle. Equal low pointer bits imply full or empty, and the corresponding request is blocked.
- Reset mid-operation: if a pop was accepted in the cycle with reset=1, rd_valid is 0 the following cycle. Stored RAM contents are not cleared and are unreachable after reset.
- Throughput: one push and one pop per cycle sustained.

Test Plan:
- Reset, then push 0xA5, 0x3C, 0xFF on consecutive cycles -> count=3, empty=0. ram_wr_addr 0,1,2 with ram_write=1.
- Pop 3 times back-to-back -> rd_valid high for 3 cycles starting one cycle after the first pop. Data A5, 3C, FF. empty=1, count=0.
- Push 16 words 0x00..0x0F -> almost_full asserts after the 14th push, full after the 16th. 17th push: ram_write=0, overflow=1, count stays 16.
- Pop when empty -> ram_read=0, rd_valid=0 next cycle, underflow=1. Push+pop same cycle while empty -> count=1, underflow=1.
- Full FIFO, simultaneous push 0x77 and pop -> pop returns oldest word, push rejected, count=15, overflow=1.
- Wrap: 20 interleaved push/pop pairs over data 0x10..0x23 -> addresses wrap 15->0, data order preserved, count stays 1. Assert reset mid-stream -> all outputs at reset values next cycle, rd_valid=0.
